cordic_rot_iter: RTL

Iterative rotation-mode CORDIC engine that consumes the micro-rotation direction bits produced by the vectoring pipeline (one `micro_rot_o` bit per vectoring stage) and replays that exact rotation sequence on further (x, y) vectors. It is the Givens-rotation step of the ICA datapath: the vectoring pipeline finds the angle, and this block applies it to the remaining row/column elements. It uses one shared add/shift datapath over NUM_STAGES cycles per vector, with valid/ready handshakes on input and output.

---
 rtl/cordic_rot_iter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: iterative rotation-mode CORDIC that replays a stored vectoring direction word on (x, y).
// Latency: NUM_STAGES cycles from acceptance to out_valid (+1 when CORDIC_SCALE_COMP_EN adds the K scaling step).
// Backpressure: valid/ready; result held in DONE until out_ready, in_ready only in READY (no out_ready->in_ready path).
// Ports: clk, nreset (async, active-low); dir_load/dir_in/dir_ready load the direction word;
//        in_valid/in_ready/x_in/y_in accept a vector; out_valid/out_ready/x_out/y_out return it.
// Optional macro CORDIC_SCALE_COMP_EN inserts a SCALE state multiplying both outputs by ~0.607422.
module cordic_rot_iter #(
  parameter int CORDIC_WIDTH = 22,
  parameter int NUM_STAGES   = 16,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           dir_load,
  input  logic [NUM_STAGES-1:0]          dir_in,
  output logic                           dir_ready,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [CORDIC_WIDTH-1:0] x_in,
  input  logic signed [CORDIC_WIDTH-1:0] y_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [CORDIC_WIDTH-1:0] x_out,
  output logic signed [CORDIC_WIDTH-1:0] y_out
);

`ifdef CORDIC_SCALE_COMP_EN
  typedef enum logic [2:0] {S_EMPTY, S_READY, S_ROTATE, S_SCALE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_EMPTY, S_READY, S_ROTATE, S_DONE} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(NUM_STAGES - 1);

  state_t                         state_q, state_d;
  logic [CNT_WIDTH-1:0]           iter_q;
  logic [NUM_STAGES-1:0]          dir_q;
  // Working copy of the direction word, shifted right once per stage so bit 0
  // is always the current stage's direction.
  logic [NUM_STAGES-1:0]          dir_work_q;
  logic signed [CORDIC_WIDTH-1:0] x_q, y_q;
  logic signed [CORDIC_WIDTH-1:0] x_sh, y_sh, x_nxt, y_nxt;

  assign dir_ready = (state_q == S_EMPTY) || (state_q == S_READY);
  assign in_ready  = (state_q == S_READY);
  assign out_valid = (state_q == S_DONE);
  assign x_out     = x_q;
  assign y_out     = y_q;

  // One shared micro-rotation: d=0 rotates clockwise, d=1 counter-clockwise.
  assign x_sh  = x_q >>> iter_q;
  assign y_sh  = y_q >>> iter_q;
  assign x_nxt = dir_work_q[0] ? (x_q - y_sh) : (x_q + y_sh);
  assign y_nxt = dir_work_q[0] ? (y_q + x_sh) : (y_q - x_sh);

`ifdef CORDIC_SCALE_COMP_EN
  // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9, each term truncated independently.
  function automatic logic signed [CORDIC_WIDTH-1:0] scale_k(input logic signed [CORDIC_WIDTH-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:  if (dir_load) state_d = S_READY;
      S_READY:  if (in_valid) state_d = S_ROTATE;
      S_ROTATE: begin
        if (iter_q == LAST_ITER) begin
`ifdef CORDIC_SCALE_COMP_EN
          state_d = S_SCALE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CORDIC_SCALE_COMP_EN
      S_SCALE:  state_d = S_DONE;
`endif
      S_DONE:   if (out_ready) state_d = S_READY;
      default:  state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      iter_q     <= '0;
      dir_q      <= '0;
      dir_work_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      if (dir_load && dir_ready) begin
        dir_q <= dir_in;
      end
      case (state_q)
        S_READY: begin
          if (in_valid) begin
            x_q        <= x_in;
            y_q        <= y_in;
            iter_q     <= '0;
            // A reload on the acceptance edge applies to this vector.
            dir_work_q <= dir_load ? dir_in : dir_q;
          end
        end
        S_ROTATE: begin
          x_q        <= x_nxt;
          y_q        <= y_nxt;
          iter_q     <= iter_q + CNT_WIDTH'(1);
          dir_work_q <= dir_work_q >> 1;
        end
`ifdef CORDIC_SCALE_COMP_EN
        S_SCALE: begin
          x_q <= scale_k(x_q);
          y_q <= scale_k(y_q);
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
